rowbuf_reader: RTL and testbench

Scan-out engine for the line buffer's read port. Given a start address and a pixel count, it drives the buffer's read port (address, clock-enable, output-enable) and turns the 1-cycle-latency RAM data into a `valid`/`ready` pixel stream for the video output stage. A 2-entry skid FIFO lets the sink stall without losing data or repeating reads.

---
 rtl/rowbuf_reader_if.sv | 33 +++
 rtl/rowbuf_reader.sv | 134 +++++++++++++
 tb/tb_rowbuf_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rowbuf_reader_if.sv
// Bundle between the line-buffer scan-out engine and its environment: line
// control, buffer read port and pixel stream. `master` is the engine side.
interface rowbuf_reader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] rb_adb;
    logic              rb_ceb;
    logic              rb_oce;
    logic [DATA_W-1:0] rb_dout;

    logic [DATA_W-1:0] px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_last;

    modport master (
        input  start, base, len, abort, rb_dout, px_ready,
        output busy, done, rb_adb, rb_ceb, rb_oce, px_data, px_valid, px_last
    );

    modport slave (
        output start, base, len, abort, rb_dout, px_ready,
        input  busy, done, rb_adb, rb_ceb, rb_oce, px_data, px_valid, px_last
    );
endinterface

// File: rtl/rowbuf_reader.sv
// Line-buffer scan-out: issues reads into a 1-cycle-latency RAM and streams the
// data through a 2-entry skid FIFO. Define ROWBUF_READER_PXDOUBLE_EN for 2x horizontal zoom.
module rowbuf_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    rowbuf_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t                 state;
    logic                   busy_r;
    logic                   done_r;
    logic [ADDR_W-1:0]      adb;
    logic [ADDR_W:0]        remaining;
    logic [ADDR_W:0]        len_r;
    logic [ADDR_W:0]        out_idx;
    logic                   inflight;

    logic [1:0][DATA_W-1:0] mem;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    logic                   px_valid;
    logic                   px_last;
    logic                   handshake;
    logic                   pop;
    logic                   ceb;
    logic [2:0]             occ;
    logic [ADDR_W:0]        last_idx;

    assign px_valid  = (count != 2'd0);
    assign handshake = px_valid && bus.px_ready;
    assign last_idx  = len_r - ONE;

`ifdef ROWBUF_READER_PXDOUBLE_EN
    // dup marks the second presentation of the FIFO head
    logic dup;
    assign pop     = handshake && dup;
    assign px_last = px_valid && dup && (out_idx == last_idx);
`else
    assign pop     = handshake;
    assign px_last = px_valid && (out_idx == last_idx);
`endif

    // Entries already owned (stored or arriving) after this cycle's pop; a new
    // read is only allowed when its data is guaranteed a slot.
    assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign ceb = (state == RUN) && (remaining != '0) && !bus.abort && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset_n || bus.abort) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            inflight  <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            out_idx   <= '0;
            remaining <= '0;
`ifdef ROWBUF_READER_PXDOUBLE_EN
            dup       <= 1'b0;
`endif
            if (!reset_n) begin
                adb   <= '0;
                len_r <= '0;
                mem   <= '0;
            end
        end else begin
            done_r   <= 1'b0;
            inflight <= ceb;
            count    <= count + {1'b0, inflight} - {1'b0, pop};

            if (ceb) begin
                adb       <= adb + ADDR_W'(1);
                remaining <= remaining - ONE;
            end
            if (inflight) begin
                mem[wr_ptr] <= bus.rb_dout;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_idx <= out_idx + ONE;
            end
`ifdef ROWBUF_READER_PXDOUBLE_EN
            if (handshake) dup <= ~dup;
`endif

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state     <= RUN;
                            busy_r    <= 1'b1;
                            adb       <= bus.base;
                            remaining <= bus.len;
                            len_r     <= bus.len;
                            out_idx   <= '0;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ceb && (remaining == ONE)) state <= DRAIN;
                end
                default: ;
            endcase

            // The line ends on the handshake of its final pixel, whatever state issued it
            if (busy_r && handshake && px_last) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rb_adb   = adb;
    assign bus.rb_ceb   = ceb;
    assign bus.rb_oce   = 1'b1;
    assign bus.px_data  = mem[rd_ptr];
    assign bus.px_valid = px_valid;
    assign bus.px_last  = px_last;
endmodule

// File: tb/tb_rowbuf_reader.sv
// Bench for rowbuf_reader: directed vector table, abort/reset sequences and
// randomized lines checked against a RAM-indexed reference stream.
module tb_rowbuf_reader;
`ifdef ROWBUF_READER_PXDOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] ram [2048];

    rowbuf_reader_if #(.ADDR_W(11), .DATA_W(8)) bus();

    rowbuf_reader #(.ADDR_W(11), .DATA_W(8)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Buffer model: one-cycle read latency
    always @(posedge clk) if (bus.rb_ceb) bus.rb_dout <= ram[bus.rb_adb];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_state(input string nm);
        check(nm, {bus.busy, bus.done, bus.rb_adb, bus.rb_ceb, bus.rb_oce,
                   bus.px_data, bus.px_valid, bus.px_last},
              {2'b00, 11'h000, 1'b0, 1'b1, 8'h00, 2'b00});
    endtask

    // Runs one line; start is driven in the current cycle when now=1, else after the next edge.
    task automatic run_line(input logic [10:0] b, input logic [11:0] l, input bit rnd,
                            input bit now, input int spur, output int done_cyc,
                            output int first_cyc, output logic [7:0] first_px,
                            output logic [7:0] last_px);
        logic [7:0] exp_d[$];
        bit         exp_l[$];
        logic [7:0] got_d[$];
        bit         got_l[$];
        int         reads, hs, bad, addr_bad, hold_bad, max_occ, occ, t0, bound;
        bit         stall;
        logic [7:0] stall_d;
        reads = 0; hs = 0; bad = 0; addr_bad = 0; hold_bad = 0; max_occ = 0;
        stall = 1'b0; stall_d = 8'h00;
        done_cyc = -1; first_cyc = -1; first_px = 8'h00; last_px = 8'h00;
        for (int k = 0; k < int'(l); k++)
            for (int r = 0; r < REP; r++) begin
                exp_d.push_back(ram[b + 11'(k)]);
                exp_l.push_back(k == int'(l) - 1 && r == REP - 1);
            end

        if (!now) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.base = b; bus.len = l;
        bus.px_ready = rnd ? 1'($urandom) : 1'b1;
        t0 = cyc;
        bound = 20 * (int'(l) + 4) + 100;
        for (int k = 0; k < bound && done_cyc < 0; k++) begin
            @(negedge clk);
            if (stall && (!bus.px_valid || bus.px_data !== stall_d)) hold_bad++;
            if (bus.rb_ceb) begin
                if (bus.rb_adb !== b + 11'(reads)) addr_bad++;
                reads++;
            end
            if (bus.px_valid && bus.px_ready) begin
                if (first_cyc < 0) first_cyc = cyc - t0;
                got_d.push_back(bus.px_data);
                got_l.push_back(bus.px_last);
                hs++;
            end
            stall   = bus.px_valid && !bus.px_ready;
            stall_d = bus.px_data;
            occ = reads - hs / REP;
            if (occ > max_occ) max_occ = occ;
            if (bus.done) done_cyc = cyc - t0;
            else begin
                @(posedge clk); #1;
                // Junk base/len after cycle 0; a spurious start lands while busy
                bus.start = (cyc - t0 == spur);
                bus.base  = 11'h300;
                bus.len   = 12'd5;
                if (rnd) bus.px_ready = 1'($urandom);
            end
        end
        bus.start = 1'b0;

        check("done seen", 32'(done_cyc >= 0), 32'd1);
        check("pixel count", got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad++;
        check("pixel sequence", bad, 0);
        check("read count", reads, 32'(l));
        check("read address", addr_bad, 0);
        check("stall hold", hold_bad, 0);
        check("fifo occupancy", 32'(max_occ <= 2), 32'd1);
        if (got_d.size() > 0) begin
            first_px = got_d[0];
            last_px  = got_d[got_d.size() - 1];
        end
    endtask

    typedef struct {
        logic [10:0] base;
        logic [11:0] len;
        logic [7:0]  first;
        logic [7:0]  last;
        int          done1;
        int          done2;
    } vec_t;

    vec_t tbl[6];
    int dc, fc;
    logic [7:0] fp, lp;

    initial begin
        tbl[0] = '{11'h010, 12'd4,    8'h10, 8'h13, 7,    11};
        tbl[1] = '{11'h7FE, 12'd4,    8'hFE, 8'h01, 7,    11};
        tbl[2] = '{11'h005, 12'd1,    8'h05, 8'h05, 4,    5};
        tbl[3] = '{11'h000, 12'd0,    8'h00, 8'h00, 1,    1};
        tbl[4] = '{11'h123, 12'd6,    8'h23, 8'h28, 9,    15};
        tbl[5] = '{11'h400, 12'd2048, 8'h00, 8'hFF, 2051, 4099};

        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
        reset_n = 1'b0;
        bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.abort = 1'b0;
        bus.px_ready = 1'b1; bus.rb_dout = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset state");
        @(posedge clk); #1; reset_n = 1'b1;

        foreach (tbl[i]) begin
            run_line(tbl[i].base, tbl[i].len, 1'b0, 1'b0, -1, dc, fc, fp, lp);
            check("done cycle", dc, (REP == 2) ? tbl[i].done2 : tbl[i].done1);
            if (tbl[i].len != 12'd0) begin
                check("first pixel cycle", fc, 3);
                check("first pixel", fp, tbl[i].first);
                check("last pixel", lp, tbl[i].last);
            end else begin
                check("no pixel on empty line", fc, -1);
            end
        end

        // start while busy is ignored
        run_line(11'h040, 12'd8, 1'b0, 1'b0, 2, dc, fc, fp, lp);
        check("done cycle busy start", dc, 8 * REP + 3);
        // stalling sink
        run_line(11'h080, 12'd8, 1'b1, 1'b0, -1, dc, fc, fp, lp);
        // back-to-back: next start in the done cycle
        run_line(11'h0A0, 12'd3, 1'b0, 1'b1, -1, dc, fc, fp, lp);
        check("done cycle back-to-back", dc, 3 * REP + 3);

        // abort on cycle 6 of a 16-pixel line
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base = 11'h100; bus.len = 12'd16; bus.px_ready = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1; bus.abort = 1'b1;
        @(negedge clk);
        check("busy before abort", bus.busy, 1'b1);
        @(posedge clk); #1; bus.abort = 1'b0;
        @(negedge clk);
        check("abort state", {bus.busy, bus.done, bus.px_valid, bus.rb_ceb}, 4'b0000);
        run_line(11'h020, 12'd3, 1'b0, 1'b0, -1, dc, fc, fp, lp);
        check("post-abort first pixel", fp, 8'h20);
        check("post-abort done cycle", dc, 3 * REP + 3);

        // reset mid-line
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base = 11'h200; bus.len = 12'd10;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset_n = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("mid-line reset state");
        run_line(11'h210, 12'd5, 1'b0, 1'b0, -1, dc, fc, fp, lp);
        check("post-reset first pixel", fp, 8'h10);

        // randomized lines over random buffer contents
        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
        for (int n = 0; n < 30; n++) begin
            logic [10:0] b;
            logic [11:0] l;
            bit rnd, now;
            int spur;
            b    = 11'($urandom);
            l    = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 40));
            rnd  = 1'($urandom);
            now  = 1'($urandom);
            spur = (l != 12'd0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : -1;
            run_line(b, l, rnd, now, spur, dc, fc, fp, lp);
            if (!rnd) check("random done cycle", dc, (l == 12'd0) ? 1 : int'(l) * REP + 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
